// File: rtl/eth_pkg.sv
// Shared 10BASE-T constants, rx state encoding and the byte-wise CRC-32 step.
package eth_pkg;

    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
    localparam int          MIN_FRAME_LEN = 64;

    typedef enum logic [2:0] {
        RX_IDLE = 3'd0,
        RX_SYNC = 3'd1,
        RX_DATA = 3'd2,
        RX_DONE = 3'd3,
        RX_DROP = 3'd4
    } rx_state_e;

    // Reflected CRC-32 advanced by one byte, data consumed LSB-first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = {1'b0, c[31:1]} ^ CRC_POLY_REFL;
            end else begin
                c = {1'b0, c[31:1]};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/manchester_rx.sv
// Manchester bit recovery: line synchroniser, mid-bit edge timing, carrier detect.
module manchester_rx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MID_THR      = (3 * CLKS_PER_BIT) / 4,
    parameter int IDLE_CLKS    = 2 * CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic eth_rx,
    output logic bit_valid,
    output logic bit_val,
    output logic carrier
);

    localparam int              CNT_W     = $clog2(IDLE_CLKS + 1);
    localparam logic [CNT_W-1:0] MID_THR_C = CNT_W'(MID_THR);
    localparam logic [CNT_W-1:0] IDLE_C    = CNT_W'(IDLE_CLKS);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_C    = CNT_W'(0);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] since_mid_q, since_mid_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic             carrier_q, carrier_d;
    logic             bit_valid_q, bit_valid_d;
    logic             bit_val_q, bit_val_d;
    logic             edge_s;
    logic             mid_s;

    // Edge classification and carrier tracking; boundary edges only refresh the idle timer.
    always_comb begin
        sync1_d     = eth_rx;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        edge_s      = sync2_q ^ prev_q;
        mid_s       = edge_s & (~carrier_q | (since_mid_q >= MID_THR_C));
        bit_valid_d = mid_s;
        bit_val_d   = sync2_q;

        if (mid_s) begin
            since_mid_d = ONE_C;
        end else if (since_mid_q < MID_THR_C) begin
            since_mid_d = since_mid_q + ONE_C;
        end else begin
            since_mid_d = since_mid_q;
        end

        if (edge_s) begin
            idle_cnt_d = ZERO_C;
            carrier_d  = 1'b1;
        end else if (carrier_q) begin
            idle_cnt_d = idle_cnt_q + ONE_C;
            carrier_d  = (idle_cnt_d != IDLE_C);
        end else begin
            idle_cnt_d = ZERO_C;
            carrier_d  = 1'b0;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            since_mid_q <= ZERO_C;
            idle_cnt_q  <= ZERO_C;
            carrier_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_val_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            since_mid_q <= since_mid_d;
            idle_cnt_q  <= idle_cnt_d;
            carrier_q   <= carrier_d;
            bit_valid_q <= bit_valid_d;
            bit_val_q   <= bit_val_d;
        end
    end

    assign bit_valid = bit_valid_q;
    assign bit_val   = bit_val_q;
    assign carrier   = carrier_q;

endmodule

// File: rtl/eth_rx2.sv
// 10BASE-T frame receiver: SFD hunt, byte write-out to BRAM, CRC-32 check, buffer handshake.
module eth_rx2
    import eth_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int MID_THR      = (3 * CLKS_PER_BIT) / 4,
    parameter int IDLE_CLKS    = 2 * CLKS_PER_BIT,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              eth_rx,
    output logic              bram_wr_en,
    output logic [ADDR_W-1:0] bram_wr_addr,
    output logic [7:0]        bram_wr_data,
    output logic              frame_done,
    output logic              frame_ok,
    output logic [ADDR_W:0]   frame_len,
    output logic              buf_full,
    input  logic              buf_release,
    output logic [7:0]        drop_count
);

    localparam int             LEN_W     = ADDR_W + 1;
    localparam logic [LEN_W-1:0] CAP_C     = LEN_W'(2 ** ADDR_W);
    localparam logic [LEN_W-1:0] MIN_LEN_C = LEN_W'(MIN_FRAME_LEN);
    localparam logic [LEN_W-1:0] ONE_C     = LEN_W'(1);

    logic bit_valid_s, bit_val_s, carrier_s;

    manchester_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .MID_THR      (MID_THR),
        .IDLE_CLKS    (IDLE_CLKS)
    ) u_mrx (
        .clk       (clk),
        .rst       (rst),
        .eth_rx    (eth_rx),
        .bit_valid (bit_valid_s),
        .bit_val   (bit_val_s),
        .carrier   (carrier_s)
    );

    rx_state_e         state_q, state_d;
    logic [7:0]        sh_q, sh_d;
    logic [4:0]        run_q, run_d;
    logic              prev_bit_q, prev_bit_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        byte_q, byte_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [31:0]       crc_q, crc_d;
    logic              ovf_q, ovf_d;
    logic              dribble_q, dribble_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              done_q, done_d;
    logic              ok_q, ok_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              full_q, full_d;
    logic [7:0]        drop_q, drop_d;
    logic [7:0]        new_sh_s, new_byte_s;

    // Frame FSM: next state, byte assembly, CRC update and handshake outputs.
    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        run_d      = run_q;
        prev_bit_d = prev_bit_q;
        bit_cnt_d  = bit_cnt_q;
        byte_d     = byte_q;
        idx_d      = idx_q;
        crc_d      = crc_q;
        ovf_d      = ovf_q;
        dribble_d  = dribble_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        ok_d       = ok_q;
        len_d      = len_q;
        full_d     = full_q;
        drop_d     = drop_q;
        new_sh_s   = {bit_val_s, sh_q[7:1]};
        new_byte_s = {bit_val_s, byte_q[7:1]};

        case (state_q)
            RX_IDLE: begin
                bit_cnt_d = 3'd0;
                idx_d     = {LEN_W{1'b0}};
                crc_d     = CRC_INIT;
                ovf_d     = 1'b0;
                dribble_d = 1'b0;
                if (bit_valid_s) begin
                    state_d    = RX_SYNC;
                    sh_d       = {bit_val_s, 7'd0};
                    run_d      = 5'd1;
                    prev_bit_d = bit_val_s;
                end else begin
                    sh_d  = 8'd0;
                    run_d = 5'd0;
                end
            end
            RX_SYNC: begin
                if (!carrier_s) begin
                    state_d = RX_IDLE;
                end else if (bit_valid_s) begin
                    sh_d       = new_sh_s;
                    prev_bit_d = bit_val_s;
                    if (bit_val_s != prev_bit_q) begin
                        run_d = (run_q == 5'd31) ? run_q : run_q + 5'd1;
                    end else begin
                        run_d = 5'd1;
                    end
                    // run_q covers the first 7 SFD bits, so >= 15 means >= 8 preamble bits
                    if ((new_sh_s == SFD_BYTE) && (run_q >= 5'd15)) begin
                        bit_cnt_d = 3'd0;
                        if (full_q) begin
                            state_d = RX_DROP;
                            drop_d  = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
                        end else begin
                            state_d = RX_DATA;
                        end
                    end else begin
                        state_d = RX_SYNC;
                    end
                end else begin
                    state_d = RX_SYNC;
                end
            end
            RX_DATA: begin
                if (!carrier_s) begin
                    state_d   = RX_DONE;
                    dribble_d = (bit_cnt_q != 3'd0);
                end else if (bit_valid_s) begin
                    byte_d    = new_byte_s;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (idx_q < CAP_C) begin
                            wr_en_d   = ~full_q;
                            wr_addr_d = idx_q[ADDR_W-1:0];
                            wr_data_d = new_byte_s;
                            crc_d     = crc32_byte(crc_q, new_byte_s);
                            idx_d     = idx_q + ONE_C;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        ovf_d = ovf_q;
                    end
                end else begin
                    state_d = RX_DATA;
                end
            end
            RX_DONE: begin
                done_d  = 1'b1;
                ok_d    = (crc_q == CRC_RESIDUE) && (idx_q >= MIN_LEN_C) && !ovf_q && !dribble_q;
                len_d   = idx_q;
                full_d  = 1'b1;
                state_d = RX_IDLE;
            end
            RX_DROP: begin
                if (!carrier_s) begin
                    state_d = RX_IDLE;
                end else begin
                    state_d = RX_DROP;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        // A release that coincides with frame completion loses to the new frame.
        if (buf_release && full_q && !done_q && (state_q != RX_DONE)) begin
            full_d = 1'b0;
            ok_d   = 1'b0;
            len_d  = {LEN_W{1'b0}};
        end else begin
            full_d = full_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RX_IDLE;
            sh_q       <= 8'd0;
            run_q      <= 5'd0;
            prev_bit_q <= 1'b0;
            bit_cnt_q  <= 3'd0;
            byte_q     <= 8'd0;
            idx_q      <= {LEN_W{1'b0}};
            crc_q      <= CRC_INIT;
            ovf_q      <= 1'b0;
            dribble_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= {ADDR_W{1'b0}};
            wr_data_q  <= 8'd0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            len_q      <= {LEN_W{1'b0}};
            full_q     <= 1'b0;
            drop_q     <= 8'd0;
        end else begin
            state_q    <= state_d;
            sh_q       <= sh_d;
            run_q      <= run_d;
            prev_bit_q <= prev_bit_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_q     <= byte_d;
            idx_q      <= idx_d;
            crc_q      <= crc_d;
            ovf_q      <= ovf_d;
            dribble_q  <= dribble_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            len_q      <= len_d;
            full_q     <= full_d;
            drop_q     <= drop_d;
        end
    end

    assign bram_wr_en   = wr_en_q;
    assign bram_wr_addr = wr_addr_q;
    assign bram_wr_data = wr_data_q;
    assign frame_done   = done_q;
    assign frame_ok     = ok_q;
    assign frame_len    = len_q;
    assign buf_full     = full_q;
    assign drop_count   = drop_q;

endmodule

// File: tb/tb_eth_rx2.sv
// Directed bench for eth_rx2: Manchester-encoded frames with hand-derived expectations.
`timescale 1ns/1ps
module tb_eth_rx2;

    logic clk = 1'b0;
    logic rst;
    logic line;
    logic sel_b;
    logic release_a, release_b;
    logic eth_rx_a, eth_rx_b;

    logic        wr_en_a, done_a, ok_a, full_a;
    logic [9:0]  addr_a;
    logic [7:0]  data_a, drop_a;
    logic [10:0] len_a;

    logic        wr_en_b, done_b, ok_b, full_b;
    logic [5:0]  addr_b;
    logic [7:0]  data_b, drop_b;
    logic [6:0]  len_b;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [7:0] tx_bytes [0:127];

    int         wr_cnt_a = 0, done_cnt_a = 0;
    logic [9:0] log_addr_a [0:1023];
    logic [7:0] log_data_a [0:1023];
    int         wr_cnt_b = 0, done_cnt_b = 0;
    logic [5:0] log_addr_b [0:127];
    logic [7:0] log_data_b [0:127];

    // 80 MHz clock; edges sit 6.25 ns away from every 50 ns line transition.
    always #6.25 clk = ~clk;

    assign eth_rx_a = sel_b ? 1'b0 : line;
    assign eth_rx_b = sel_b ? line : 1'b0;

    eth_rx2 #(.ADDR_W(10)) dut_a (
        .clk(clk), .rst(rst), .eth_rx(eth_rx_a),
        .bram_wr_en(wr_en_a), .bram_wr_addr(addr_a), .bram_wr_data(data_a),
        .frame_done(done_a), .frame_ok(ok_a), .frame_len(len_a),
        .buf_full(full_a), .buf_release(release_a), .drop_count(drop_a)
    );

    eth_rx2 #(.ADDR_W(6)) dut_b (
        .clk(clk), .rst(rst), .eth_rx(eth_rx_b),
        .bram_wr_en(wr_en_b), .bram_wr_addr(addr_b), .bram_wr_data(data_b),
        .frame_done(done_b), .frame_ok(ok_b), .frame_len(len_b),
        .buf_full(full_b), .buf_release(release_b), .drop_count(drop_b)
    );

    // Write / frame_done logger for both instances, sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_en_a && wr_cnt_a < 1024) begin
            log_addr_a[wr_cnt_a] <= addr_a;
            log_data_a[wr_cnt_a] <= data_a;
        end
        if (wr_en_a) wr_cnt_a <= wr_cnt_a + 1;
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (wr_en_b && wr_cnt_b < 128) begin
            log_addr_b[wr_cnt_b] <= addr_b;
            log_data_b[wr_cnt_b] <= data_b;
        end
        if (wr_en_b) wr_cnt_b <= wr_cnt_b + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame of n bytes 0,1,2,... followed by its FCS (complemented CRC, low byte first).
    task automatic build_frame(input int n);
        logic [31:0] r;
        logic        fb;
        r = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            tx_bytes[i] = i[7:0];
            for (int b = 0; b < 8; b++) begin
                fb = r[0] ^ tx_bytes[i][b];
                r  = r >> 1;
                if (fb) r = r ^ 32'hEDB8_8320;
            end
        end
        r = ~r;
        tx_bytes[n]   = r[7:0];
        tx_bytes[n+1] = r[15:8];
        tx_bytes[n+2] = r[23:16];
        tx_bytes[n+3] = r[31:24];
    endtask

    task automatic send_bit(input logic b);
        line = ~b;
        #50;
        line = b;
        #50;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic send_head();
        for (int i = 0; i < 7; i++) send_byte(8'h55);
        send_byte(8'hD5);
    endtask

    // TP_IDL high hold, then line off and time for carrier loss and noise recovery.
    task automatic send_tail();
        line = 1'b1;
        #250;
        line = 1'b0;
        #650;
    endtask

    task automatic send_frame(input int n, input int dribble);
        send_head();
        for (int i = 0; i < n; i++) send_byte(tx_bytes[i]);
        for (int i = 0; i < dribble; i++) send_bit(i[0] ^ 1'b1);
        send_tail();
    endtask

    task automatic pulse_release_a();
        @(negedge clk);
        release_a = 1'b1;
        @(negedge clk);
        release_a = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic verify_a(input string tag, input int wr0, input int dn0, input int exp_wr, input int exp_done);
        int n;
        n = wr_cnt_a - wr0;
        check_val({tag, "_writes"}, n, exp_wr);
        check_val({tag, "_done"}, done_cnt_a - dn0, exp_done);
        for (int i = 0; i < n && i < 128; i++) begin
            check_val({tag, "_addr"}, log_addr_a[wr0 + i], i);
            check_val({tag, "_data"}, log_data_a[wr0 + i], tx_bytes[i]);
        end
    endtask

    initial begin
        int wr0, dn0;
        rst = 1'b1; line = 1'b0; sel_b = 1'b0; release_a = 1'b0; release_b = 1'b0;
        repeat (4) @(negedge clk);
        check_val("rst_wr_en", wr_en_a, 0);
        check_val("rst_done", done_a, 0);
        check_val("rst_ok", ok_a, 0);
        check_val("rst_len", len_a, 0);
        check_val("rst_full", full_a, 0);
        check_val("rst_drop", drop_a, 0);
        check_val("rst_b_full", full_b, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: good 64-byte frame
        build_frame(60);
        wr0 = wr_cnt_a; dn0 = done_cnt_a;
        send_frame(64, 0);
        verify_a("t1", wr0, dn0, 64, 1);
        check_val("t1_ok", ok_a, 1);
        check_val("t1_len", len_a, 64);
        check_val("t1_full", full_a, 1);
        pulse_release_a();
        check_val("t1_release_full", full_a, 0);

        // 2: bit 3 of byte 20 corrupted after FCS computed
        build_frame(60);
        tx_bytes[20] = tx_bytes[20] ^ 8'h08;
        wr0 = wr_cnt_a; dn0 = done_cnt_a;
        send_frame(64, 0);
        verify_a("t2", wr0, dn0, 64, 1);
        check_val("t2_ok", ok_a, 0);
        check_val("t2_len", len_a, 64);
        check_val("t2_full", full_a, 1);

        // 3: frame while buffer locked is dropped; after release the next is accepted
        build_frame(60);
        wr0 = wr_cnt_a; dn0 = done_cnt_a;
        send_frame(64, 0);
        check_val("t3_drop_writes", wr_cnt_a - wr0, 0);
        check_val("t3_drop_done", done_cnt_a - dn0, 0);
        check_val("t3_drop_count", drop_a, 1);
        check_val("t3_still_full", full_a, 1);
        pulse_release_a();
        check_val("t3_release_full", full_a, 0);
        wr0 = wr_cnt_a; dn0 = done_cnt_a;
        send_frame(64, 0);
        verify_a("t3", wr0, dn0, 64, 1);
        check_val("t3_ok", ok_a, 1);
        check_val("t3_len", len_a, 64);
        pulse_release_a();

        // 4: 70-byte frame into a 64-byte buffer
        build_frame(66);
        sel_b = 1'b1;
        send_frame(70, 0);
        sel_b = 1'b0;
        check_val("t4_writes", wr_cnt_b, 64);
        check_val("t4_done", done_cnt_b, 1);
        for (int i = 0; i < wr_cnt_b && i < 128; i++) begin
            check_val("t4_addr", log_addr_b[i], i);
            check_val("t4_data", log_data_b[i], tx_bytes[i]);
        end
        check_val("t4_ok", ok_b, 0);
        check_val("t4_len", len_b, 64);
        check_val("t4_full", full_b, 1);

        // 5: link pulse is silently ignored; frame with 4 dribble bits is rejected
        wr0 = wr_cnt_a; dn0 = done_cnt_a;
        line = 1'b1;
        #100;
        line = 1'b0;
        #600;
        check_val("t5_nlp_writes", wr_cnt_a - wr0, 0);
        check_val("t5_nlp_done", done_cnt_a - dn0, 0);
        build_frame(60);
        wr0 = wr_cnt_a; dn0 = done_cnt_a;
        send_frame(64, 4);
        verify_a("t5", wr0, dn0, 64, 1);
        check_val("t5_ok", ok_a, 0);
        check_val("t5_len", len_a, 64);
        pulse_release_a();

        // 6: reset in the middle of byte 30, rest of the frame keeps arriving
        build_frame(60);
        wr0 = wr_cnt_a; dn0 = done_cnt_a;
        send_head();
        for (int i = 0; i < 30; i++) send_byte(tx_bytes[i]);
        for (int i = 0; i < 4; i++) send_bit(tx_bytes[30][i]);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("t6_rst_wr_en", wr_en_a, 0);
        check_val("t6_rst_done", done_a, 0);
        check_val("t6_rst_full", full_a, 0);
        check_val("t6_rst_drop", drop_a, 0);
        check_val("t6_rst_b_full", full_b, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 4; i < 8; i++) send_bit(tx_bytes[30][i]);
        for (int i = 31; i < 64; i++) send_byte(tx_bytes[i]);
        send_tail();
        check_val("t6_abort_writes", wr_cnt_a - wr0, 30);
        check_val("t6_abort_done", done_cnt_a - dn0, 0);
        wr0 = wr_cnt_a; dn0 = done_cnt_a;
        send_frame(64, 0);
        verify_a("t6", wr0, dn0, 64, 1);
        check_val("t6_ok", ok_a, 1);
        check_val("t6_len", len_a, 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
